// File: rtl/imo_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imo_arb_pkg
//  Purpose  : Shared types and helpers for the IMO request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package imo_arb_pkg;

   // Upper bound on channel count; the round-robin helper works on this width.
   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   // First valid channel strictly after 'last', searching cyclically over
   // num_ch channels. Returns 'last' when nothing is valid.
   function automatic int rr_next(input logic [MAX_CH-1:0] valid,
                                  input int                last,
                                  input int                num_ch);
      int pick;
      int idx;
      pick = last;
      // Walk from farthest to nearest so the nearest valid channel wins.
      for (int k = MAX_CH; k >= 1; k--) begin
         idx = (last + k) % num_ch;
         if ((k <= num_ch) && valid[idx[2:0]]) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imo_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : imo_req_arbiter_if
//  Purpose  : Channel-side and memory-controller-side signals of the arbiter.
//             'master' is the arbiter view (it masters the MC request port),
//             'slave' is the surrounding environment view.
//  Revision : 1.0 - initial release
// ============================================================================
interface imo_req_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int INST_W = 128,
   parameter int DATA_W = 512
);
   logic [NUM_CH-1:0]        ch_req_valid;
   logic [NUM_CH*INST_W-1:0] ch_req_inst;
   logic [NUM_CH-1:0]        ch_req_ack;
   logic [NUM_CH-1:0]        ch_resp_valid;
   logic [DATA_W-1:0]        ch_resp_data;
   logic                     imo_req_valid;
   logic                     imo_req_ack;
   logic [INST_W-1:0]        imo_req_inst;
   logic                     imo_resp_valid;
   logic [DATA_W-1:0]        imo_resp_data;

   modport master (
      input  ch_req_valid, ch_req_inst, imo_req_ack, imo_resp_valid, imo_resp_data,
      output ch_req_ack, ch_resp_valid, ch_resp_data, imo_req_valid, imo_req_inst
   );

   modport slave (
      output ch_req_valid, ch_req_inst, imo_req_ack, imo_resp_valid, imo_resp_data,
      input  ch_req_ack, ch_resp_valid, ch_resp_data, imo_req_valid, imo_req_inst
   );
endinterface
`default_nettype wire

// File: rtl/imo_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : imo_id_fifo
//  Purpose  : In-order FIFO of issuing channel ids for outstanding responses.
//  Revision : 1.0 - initial release
// ============================================================================
module imo_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Never overflow or underflow, whatever the caller does.
   assign do_push = push && (count != FULL_CNT);
   assign do_pop  = pop  && (count != '0);
   assign head    = mem[rd_ptr];

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/imo_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imo_req_arbiter
//  Purpose  : Round-robin arbiter of NUM_CH IMO requesters onto the memory
//             controller IMO port, with in-order response routing.
//  Revision : 1.0 - initial release
// ============================================================================
module imo_req_arbiter
   import imo_arb_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int INST_W    = 128,
   parameter int DATA_W    = 512,
   parameter int MAX_OUTST = 4,
   parameter int RESP_BIT  = 127
) (
   input  logic                        clk,
   input  logic                        rst_n,
   imo_req_arbiter_if.master           bus,
   output logic [$clog2(MAX_OUTST):0]  outstanding,
   output logic                        orphan_err
);
   localparam int GW = $clog2(NUM_CH);
   localparam int CW = $clog2(MAX_OUTST) + 1;
   localparam logic [CW-1:0]     FULL_CNT = CW'(MAX_OUTST);
   localparam logic [NUM_CH-1:0] ONE      = NUM_CH'(1);

   arb_state_t        state;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     nxt_g;
   logic              can_grant;
   logic              push;
   logic              pop;
   logic              empty;
   logic [GW-1:0]     head;
   logic [CW-1:0]     count;
   logic [INST_W-1:0] ch_inst [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_inst[i] = bus.ch_req_inst[i*INST_W +: INST_W];
   end

   assign nxt_g     = GW'(rr_next(MAX_CH'(bus.ch_req_valid), int'(last_grant), NUM_CH));
   assign can_grant = (|bus.ch_req_valid) && (count < FULL_CNT);
   // last_grant holds the channel currently being served while in REQ.
   assign push      = (state == REQ) && bus.imo_req_ack && bus.imo_req_inst[RESP_BIT];
   assign empty     = (count == '0);
   assign pop       = bus.imo_resp_valid && !empty;
   assign outstanding = count;

   imo_id_fifo #(
      .WIDTH (GW),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (last_grant),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Request FSM: arbitrate in IDLE, hold the request in REQ, ack in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         last_grant        <= GW'(NUM_CH - 1);
         bus.imo_req_valid <= 1'b0;
         bus.imo_req_inst  <= '0;
         bus.ch_req_ack    <= '0;
      end else begin
         bus.ch_req_ack <= '0;
         case (state)
            IDLE: begin
               if (can_grant) begin
                  last_grant        <= nxt_g;
                  bus.imo_req_inst  <= ch_inst[nxt_g];
                  bus.imo_req_valid <= 1'b1;
                  state             <= REQ;
               end
            end
            REQ: begin
               if (bus.imo_req_ack) begin
                  bus.imo_req_valid <= 1'b0;
                  bus.ch_req_ack    <= ONE << last_grant;
                  state             <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Response routing to the head-of-FIFO channel, plus sticky orphan flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ch_resp_valid <= '0;
         bus.ch_resp_data  <= '0;
         orphan_err        <= 1'b0;
      end else begin
         bus.ch_resp_valid <= pop ? (ONE << head) : '0;
         if (pop) begin
            bus.ch_resp_data <= bus.imo_resp_data;
         end
         if (bus.imo_resp_valid && empty) begin
            orphan_err <= 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_imo_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imo_req_arbiter
//  Purpose  : Directed self-checking bench for imo_req_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imo_req_arbiter;
   localparam int NUM_CH = 4;
   localparam int INST_W = 128;
   localparam int DATA_W = 512;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] outstanding;
   logic       orphan_err;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   imo_req_arbiter_if #(.NUM_CH(NUM_CH), .INST_W(INST_W), .DATA_W(DATA_W)) bus ();

   imo_req_arbiter #(
      .NUM_CH(NUM_CH), .INST_W(INST_W), .DATA_W(DATA_W), .MAX_OUTST(4), .RESP_BIT(127)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .outstanding (outstanding),
      .orphan_err  (orphan_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit           kind;     // 0 = request, 1 = response
      int           ch;
      logic [511:0] val;      // inst (low 128 bits) or response data
      int           dly;
      logic [3:0]   exp_oh;
      int           exp_out;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.imo_req_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("req_valid_timeout", 0, 1);
   endtask

   task automatic do_req(input int ch, input logic [127:0] inst, input int dly,
                         input logic [3:0] exp_oh, input int exp_out, input string nm);
      bit ok;
      bus.ch_req_inst[ch*INST_W +: INST_W] = inst;
      bus.ch_req_valid[ch] = 1'b1;
      @(negedge clk);
      wait_req(ok);
      chk({nm, "_inst"}, bus.imo_req_inst, inst);
      repeat (dly) @(negedge clk);
      bus.imo_req_ack = 1'b1;
      @(negedge clk);
      bus.imo_req_ack = 1'b0;
      chk({nm, "_ack"}, bus.ch_req_ack, exp_oh);
      chk({nm, "_reqv_low"}, bus.imo_req_valid, 0);
      chk({nm, "_outst"}, outstanding, exp_out);
      bus.ch_req_valid[ch] = 1'b0;
      @(negedge clk);
      chk({nm, "_ack_pulse"}, bus.ch_req_ack, 0);
   endtask

   task automatic do_resp(input logic [511:0] data, input logic [3:0] exp_oh,
                          input int exp_out, input string nm);
      bus.imo_resp_data  = data;
      bus.imo_resp_valid = 1'b1;
      @(negedge clk);
      bus.imo_resp_valid = 1'b0;
      chk({nm, "_rvalid"}, bus.ch_resp_valid, exp_oh);
      if (exp_oh != 4'b0000) chk({nm, "_rdata"}, bus.ch_resp_data, data);
      chk({nm, "_outst"}, outstanding, exp_out);
      @(negedge clk);
      chk({nm, "_rvalid_pulse"}, bus.ch_resp_valid, 0);
   endtask

   task automatic do_reset();
      bus.ch_req_valid   = '0;
      bus.imo_req_ack    = 1'b0;
      bus.imo_resp_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit ok;
      int last_t;
      int t;
      bus.ch_req_valid   = '0;
      bus.ch_req_inst    = '0;
      bus.imo_req_ack    = 1'b0;
      bus.imo_resp_valid = 1'b0;
      bus.imo_resp_data  = '0;

      tbl[0] = '{1'b0, 2, 512'(128'h8000_0000_0000_0000_0000_0000_0000_0001), 2, 4'b0100, 1};
      tbl[1] = '{1'b1, 0, {16{32'hA5A5_A5A5}},                                  0, 4'b0100, 0};
      tbl[2] = '{1'b0, 3, 512'(128'h8000_0000_0000_0000_0000_0000_0000_0003), 0, 4'b1000, 1};
      tbl[3] = '{1'b0, 1, 512'(128'h8000_0000_0000_0000_0000_0000_0000_0011), 1, 4'b0010, 2};
      tbl[4] = '{1'b0, 3, 512'(128'h8000_0000_0000_0000_0000_0000_0000_0033), 0, 4'b1000, 3};
      tbl[5] = '{1'b1, 0, {16{32'hD0D0_0000}},                                  0, 4'b1000, 2};
      tbl[6] = '{1'b1, 0, {16{32'hD1D1_1111}},                                  0, 4'b0010, 1};
      tbl[7] = '{1'b1, 0, {16{32'hD2D2_2222}},                                  0, 4'b1000, 0};
      tbl[8] = '{1'b0, 0, 512'(128'h0000_0000_0000_0000_0000_0000_0000_0077), 0, 4'b0001, 0};

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      chk("rst_reqv",   bus.imo_req_valid, 0);
      chk("rst_inst",   bus.imo_req_inst, 0);
      chk("rst_ack",    bus.ch_req_ack, 0);
      chk("rst_rvalid", bus.ch_resp_valid, 0);
      chk("rst_rdata",  bus.ch_resp_data, 0);
      chk("rst_outst",  outstanding, 0);
      chk("rst_orphan", orphan_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, in-order routing and a no-response instruction.
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].kind == 1'b0)
            do_req(tbl[i].ch, tbl[i].val[127:0], tbl[i].dly, tbl[i].exp_oh,
                   tbl[i].exp_out, $sformatf("v%0d", i));
         else
            do_resp(tbl[i].val, tbl[i].exp_oh, tbl[i].exp_out, $sformatf("v%0d", i));
      end

      // Orphan response.
      chk("orphan_before", orphan_err, 0);
      do_resp({16{32'h0BAD_0BAD}}, 4'b0000, 0, "orphan");
      chk("orphan_set", orphan_err, 1);
      do_reset();
      chk("orphan_cleared", orphan_err, 0);

      // Round robin with all channels requesting.
      for (int c = 0; c < 4; c++) begin
         bus.ch_req_inst[c*INST_W +: INST_W] = 128'(32'h100 + c);
      end
      bus.ch_req_valid = 4'b1111;
      @(negedge clk);
      last_t = 0;
      for (int k = 0; k < 4; k++) begin
         wait_req(ok);
         t = cyc;
         chk($sformatf("rr%0d_inst", k), bus.imo_req_inst, 128'(32'h100 + k));
         if (k > 0) chk($sformatf("rr%0d_spacing", k), t - last_t, 3);
         last_t = t;
         bus.imo_req_ack = 1'b1;
         @(negedge clk);
         bus.imo_req_ack = 1'b0;
         chk($sformatf("rr%0d_ack", k), bus.ch_req_ack, 4'b0001 << k);
         bus.ch_req_valid[k] = 1'b0;
         @(negedge clk);
      end
      do_req(0, 128'h100, 0, 4'b0001, 0, "rr_again");

      // FIFO full: four response-producing requests, fifth held back.
      for (int c = 0; c < 4; c++) begin
         do_req(c, {1'b1, 127'(32'h200 + c)}, 0, 4'b0001 << c, c + 1, $sformatf("full%0d", c));
      end
      bus.ch_req_inst[1*INST_W +: INST_W] = {1'b1, 127'h555};
      bus.ch_req_valid[1] = 1'b1;
      repeat (5) @(negedge clk);
      chk("full_held_reqv", bus.imo_req_valid, 0);
      chk("full_outst", outstanding, 4);
      bus.imo_resp_data  = {16{32'hF00D_F00D}};
      bus.imo_resp_valid = 1'b1;
      @(negedge clk);
      bus.imo_resp_valid = 1'b0;
      chk("full_pop_rvalid", bus.ch_resp_valid, 4'b0001);
      chk("full_pop_outst", outstanding, 3);
      @(negedge clk);
      chk("full_fifth_reqv", bus.imo_req_valid, 1);
      chk("full_fifth_inst", bus.imo_req_inst, {1'b1, 127'h555});
      bus.imo_req_ack = 1'b1;
      @(negedge clk);
      bus.imo_req_ack = 1'b0;
      chk("full_fifth_ack", bus.ch_req_ack, 4'b0010);
      chk("full_fifth_outst", outstanding, 4);
      bus.ch_req_valid[1] = 1'b0;
      @(negedge clk);

      // Reset in the middle of a request with two responses outstanding.
      do_reset();
      do_req(1, {1'b1, 127'h61}, 0, 4'b0010, 1, "mid1");
      do_req(2, {1'b1, 127'h62}, 0, 4'b0100, 2, "mid2");
      bus.ch_req_inst[3*INST_W +: INST_W] = {1'b1, 127'h63};
      bus.ch_req_valid[3] = 1'b1;
      @(negedge clk);
      wait_req(ok);
      chk("mid_in_req", bus.imo_req_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_async_reqv", bus.imo_req_valid, 0);
      chk("mid_async_outst", outstanding, 0);
      bus.ch_req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.ch_req_inst[2*INST_W +: INST_W] = 128'h72;
      bus.ch_req_valid[2] = 1'b1;
      do_req(0, 128'h70, 0, 4'b0001, 0, "post_rst");
      bus.ch_req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/imo_req_arbiter.md
Name: imo_req_arbiter

Overview:
- Multi-channel front end for the memory controller's in-memory-operation (IMO) port.
- Arbitrates NUM_CH independent IMO requesters round-robin onto the single imo_req_valid/imo_req_ack/imo_req_inst interface of the memory controller.
- Records the issuing channel of every response-producing request in an in-order ID FIFO and routes each imo_resp_valid/imo_resp_data back to that channel.
- Sits between the per-core IMO controllers and the memory controller top, in the ui_clk domain.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- INST_W, 128, IMO instruction width.
- DATA_W, 512, response data width.
- MAX_OUTST, 4, ID FIFO depth, which is the maximum number of outstanding responses (power of 2, ≥2).
- RESP_BIT, 127, instruction bit that is 1 when the instruction returns a response.

Ports:
- clk  in  1  ui_clk.
- rst_n  in  1  asynchronous active-low reset.
- ch_req_valid  in  NUM_CH  per-channel request valid; held until that channel's ack.
- ch_req_inst  in  NUM_CH*INST_W  per-channel instruction; channel i occupies bits [i*INST_W +: INST_W].
- ch_req_ack  out  NUM_CH  one-cycle acknowledge pulse, one-hot.
- ch_resp_valid  out  NUM_CH  one-cycle response pulse, one-hot.
- ch_resp_data  out  DATA_W  response data, shared by all channels; valid when any ch_resp_valid bit is 1.
- imo_req_valid  out  1  request to the memory controller.
- imo_req_ack  in  1  memory controller accepted the request (one-cycle pulse).
- imo_req_inst  out  INST_W  instruction to the memory controller.
- imo_resp_valid  in  1  memory controller response pulse.
- imo_resp_data  in  DATA_W  memory controller response data.
- outstanding  out  $clog2(MAX_OUTST)+1  current ID FIFO occupancy.
- orphan_err  out  1  sticky: a response arrived while the ID FIFO was empty.

Behaviour:
- Reset (async assert, synchronous release): all outputs 0, FSM in IDLE, FIFO empty, last_grant = NUM_CH-1 so channel 0 has first priority.
- FSM states:
  - IDLE: if any ch_req_valid and occupancy < MAX_OUTST, grant the first valid channel strictly after last_grant (cyclic). Latch its inst into imo_req_inst, update last_grant, go to REQ. Otherwise stay in IDLE.
  - REQ: imo_req_valid=1, imo_req_inst stable. On imo_req_ack, go to DONE; if latched inst[RESP_BIT]=1, push the grant id into the FIFO in that cycle.
  - DONE: imo_req_valid=0, ch_req_ack[grant]=1 for exactly this cycle, then return to IDLE. DONE is a mandatory gap so the acked channel can drop valid before the next arbitration.
- Timing: minimum 3 cycles per request (IDLE→REQ→DONE). ch_req_ack rises 1 cycle after imo_req_ack.
- All outputs are driven from flops; there is no combinational input→output path.
- A channel deasserting valid before its ack is a protocol violation; the request already latched is still issued.
- Response path: on imo_resp_valid with FIFO non-empty, pop the head id. Next cycle ch_resp_valid[id]=1 and ch_resp_data = the registered imo_resp_data (latency 1). ch_resp_data holds its last value otherwise.
- Orphan response: imo_resp_valid with FIFO empty is dropped, orphan_err set (cleared only by reset), no ch_resp_valid pulse.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. A pop frees its slot for the IDLE check on the following cycle.
- Full FIFO: no new grant while occupancy == MAX_OUTST. A request already in REQ still completes, because the grant check guaranteed a free slot.
- FIFO pointers are $clog2(MAX_OUTST) bits and wrap modulo MAX_OUTST. outstanding = count register.
- imo_req_ack outside REQ is ignored.
- Reset during REQ: imo_req_valid drops immediately and the FIFO is cleared.

Decomposition:
- Package imo_arb_pkg holds the FSM state enum (IDLE/REQ/DONE) and the helper function for round-robin next-grant.
- Sub-module imo_id_fifo: synchronous FIFO, width $clog2(NUM_CH), depth MAX_OUTST, with count output, same clk/rst_n.

Test Plan:
- Single request: ch2 valid, inst=0x8000…0001, imo_req_ack 2 cycles after imo_req_valid → imo_req_inst matches; ch_req_ack=4'b0100 one cycle after ack; outstanding=1. Then imo_resp_valid with data 0xA5… → ch_resp_valid=4'b0100 next cycle with data 0xA5…; outstanding=0.
- Round robin: all 4 channels valid, each dropping valid after its ack, immediate ack → grant order 0,1,2,3, then 0 again when ch0 re-asserts; 3 cycles per grant.
- FIFO full: MAX_OUTST=4, 5 response-producing requests with no responses → only 4 issued, outstanding=4, 5th held; one response → 5th issues within 2 cycles.
- In-order routing: requests from ch3, ch1, ch3 (RESP_BIT=1), then 3 responses D0, D1, D2 → ch3:D0, ch1:D1, ch3:D2.
- No-response inst and orphan: request with inst[127]=0 → no push, outstanding=0; a following imo_resp_valid → orphan_err=1, no ch_resp_valid.
- Reset mid-operation: rst_n low while in REQ with outstanding=2 → imo_req_valid=0 asynchronously, outstanding=0; after release, ch0 wins first.
